// File: rtl/stack_ctrl_pkg.sv
// Shared types for the stack controller: FSM state encoding and the stack select codes
// driven towards the external shift-register stack.
package stack_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POP,
      RPOP,
      RPUSH,
      DONE
   } state_e;

   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_PUSH = 2'b10;
   localparam logic [1:0] S_POP  = 2'b01;

   // The stack select is a pure function of the state, so it can never glitch on inputs.
   function automatic logic [1:0] selOf(input state_e s);
      case (s)
         PUSH, RPUSH: return S_PUSH;
         POP, RPOP:   return S_POP;
         default:     return S_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Handshaked push/pop/replace controller for an external shift-register stack; tracks depth,
// rejects over/underflow without touching the stack, and keeps sticky error flags.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int DW   = $clog2(DEPTH) + 1
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          push_req,
   input  logic          pop_req,
   input  logic [W-1:0]  din,
   input  logic          err_clr,
   output logic          ack,
   output logic          rej,
   output logic [W-1:0]  dout,
   output logic          dout_vld,
   output logic          busy,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty,
   output logic          ovf_err,
   output logic          unf_err,
   output logic [1:0]    stk_s,
   output logic [W-1:0]  stk_i,
   input  logic [W-1:0]  stk_t
);

   state_e        state_q;
   logic [W-1:0]  din_q;
   logic [W-1:0]  dout_q;
   logic [DW-1:0] depth_q;
   logic          ack_q;
   logic          rej_q;
   logic          vld_q;
   logic          ovf_q;
   logic          unf_q;
   logic          full_w;
   logic          empty_w;

   assign full_w  = (depth_q == DW'(DEPTH));
   assign empty_w = (depth_q == '0);

   // Requests are only looked at in IDLE; ack/rej/dout_vld are registered on entry to DONE
   // so they are high exactly for the DONE cycle. Error sets are written after the clear
   // so that a simultaneous set wins.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         din_q   <= '0;
         dout_q  <= '0;
         depth_q <= '0;
         ack_q   <= 1'b0;
         rej_q   <= 1'b0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         rej_q <= 1'b0;
         vld_q <= 1'b0;
         if (err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (push_req && !pop_req) begin
                  if (!full_w) begin
                     state_q <= PUSH;
                     din_q   <= din;
                  end else begin
                     state_q <= DONE;
                     ack_q   <= 1'b1;
                     rej_q   <= 1'b1;
                     ovf_q   <= 1'b1;
                  end
               end else if (pop_req) begin
                  if (empty_w) begin
                     state_q <= DONE;
                     ack_q   <= 1'b1;
                     rej_q   <= 1'b1;
                     unf_q   <= 1'b1;
                  end else if (push_req) begin
                     state_q <= RPOP;
                     din_q   <= din;
                  end else begin
                     state_q <= POP;
                  end
               end
            end
            PUSH: begin
               if (!full_w) depth_q <= depth_q + DW'(1);
               state_q <= DONE;
               ack_q   <= 1'b1;
            end
            POP: begin
               dout_q  <= stk_t;
               if (!empty_w) depth_q <= depth_q - DW'(1);
               state_q <= DONE;
               ack_q   <= 1'b1;
               vld_q   <= 1'b1;
            end
            RPOP: begin
               dout_q  <= stk_t;
               state_q <= RPUSH;
            end
            RPUSH: begin
               state_q <= DONE;
               ack_q   <= 1'b1;
               vld_q   <= 1'b1;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign rej      = rej_q;
   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign busy     = (state_q != IDLE);
   assign depth    = depth_q;
   assign full     = full_w;
   assign empty    = empty_w;
   assign ovf_err  = ovf_q;
   assign unf_err  = unf_q;
   assign stk_s    = selOf(state_q);
   assign stk_i    = din_q;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter W, default 8: stack data width in bits.
REQ-002 Parameter DEPTH, default 4: stack entry count; depth counter is clog2(DEPTH)+1 bits wide.
REQ-003 Clocking SHALL be one clock and one reset: reset is asynchronous and active-low.
REQ-004 ck  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 push_req  in  1  push request; held until ack.
REQ-007 pop_req  in  1  pop request; held until ack.
REQ-008 din  in  W  push data; sampled when request accepted.
REQ-009 err_clr  in  1  synchronous clear of sticky error flags.
REQ-010 ack  out  1  one-cycle pulse: operation finished or rejected.
REQ-011 rej  out  1  qualifies ack: request rejected, stack untouched.
REQ-012 dout  out  W  popped value; held until the next pop.
REQ-013 dout_vld  out  1  pulses with ack on a successful pop or replace.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 depth  out  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-016 full / empty  out  1 each  depth==DEPTH / depth==0.
REQ-017 ovf_err / unf_err  out  1 each  sticky overflow / underflow flags.
REQ-018 stk_s  out  2  stack select: 00 hold, 10 push, 01 pop.
REQ-019 stk_i  out  W  stack push data.
REQ-020 stk_t  in  W  stack top-of-stack value.

Function
REQ-021 FSM states SHALL be: IDLE, PUSH, POP, RPOP, RPUSH, DONE; stk_s decodes from state only: PUSH/RPUSH=10, POP/RPOP=01, all others=00.
REQ-022 Requests SHALL be sampled only in IDLE; requests in any other state are ignored.
REQ-023 IDLE transitions: push only, not full -> PUSH; pop only, not empty -> POP; both, not empty -> RPOP; push only, full -> DONE with rej, ovf_err set; pop or both, empty -> DONE with rej, unf_err set; none -> IDLE.
REQ-024 din SHALL be registered into din_q on acceptance; stk_i=din_q in every state.
REQ-025 PUSH: one cycle; depth+1 at its closing edge; -> DONE.
REQ-026 POP: one cycle; dout<=stk_t at its closing edge, i.e. before the stack shifts; depth-1; -> DONE.
REQ-027 RPOP: one cycle; dout<=stk_t; -> RPUSH. RPUSH: one cycle, pushes din_q; -> DONE. Net depth is unchanged.
REQ-028 DONE: ack=1 for one cycle; rej and dout_vld are valid here; -> IDLE.
REQ-029 Latency from the accepting edge to ack is 2 cycles for push/pop, 3 for replace, 1 for a rejection.
REQ-030 If err_clr and an error set occur on the same edge, set SHALL win.
REQ-031 depth SHALL never leave 0..DEPTH; a stack shift SHALL never be issued on a rejected request.

Reset
REQ-032 Asserting rst_n low, including mid-operation, SHALL immediately force state=IDLE, stk_s=00, depth=0, dout=0, din_q=0, ack=rej=dout_vld=busy=0, and ovf_err=unf_err=0; empty=1, full=0.
REQ-033 Stack contents are not reset; depth=0 makes them unreachable, and the first push after reset is valid top.

Structure
REQ-034 Package stack_ctrl_pkg SHALL hold the state enum and the select constants S_HOLD=2'b00, S_PUSH=2'b10, S_POP=2'b01.
REQ-035 No sub-module SHALL exist; the parent instances the stack beside stack_ctrl and connects stk_s/stk_i/stk_t.

Verification
REQ-036 After reset, push 0xA1, 0xB2, 0xC3, 0xD4 -> each acks 2 cycles after acceptance with rej=0; depth=4, full=1, stk_t=0xD4.
REQ-037 On a full stack, push 0xEE -> ack with rej=1 one cycle later, ovf_err=1, stk_s stays 00, depth=4.
REQ-038 Pop 4 times -> dout=0xD4, 0xC3, 0xB2, 0xA1 with dout_vld; then pop again -> rej=1, unf_err=1, depth=0.
REQ-039 Depth 2 with top 0x55: push_req+pop_req, din=0x77 -> dout=0x55, stk_t=0x77, depth=2, ack 3 cycles after acceptance.
REQ-040 rst_n low during the PUSH cycle -> stk_s=00 immediately, depth=0, no ack; err_clr together with a new overflow -> ovf_err stays 1.
